// File: rtl/rob_param_pkg.sv
// Shared types for the reorder buffer: instruction class and the default tag type.
package rob_param_pkg;

    typedef enum logic [1:0] {
        OpAlu = 2'd0,
        OpLd  = 2'd1,
        OpSt  = 2'd2,
        OpBr  = 2'd3
    } op_t;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

endpackage

// File: rtl/rob_param_age_mask.sv
// Marks every occupied entry strictly younger than a given branch tag, measured from head.
module rob_param_age_mask #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic [TAG_W:0]   head_ptr,
    input  logic [TAG_W:0]   tail_ptr,
    input  logic [TAG_W-1:0] br_tag,
    output logic [DEPTH-1:0] younger,
    output logic [TAG_W-1:0] br_dist
);

    logic [TAG_W:0]   occ;
    logic [TAG_W-1:0] idx_dist;

    always_comb begin
        occ      = tail_ptr - head_ptr;
        br_dist  = br_tag - head_ptr[TAG_W-1:0];
        idx_dist = '0;
        younger  = '0;
        // Age is the modular distance from head; younger means further than the branch yet
        // still inside the occupied window.
        for (int i = 0; i < DEPTH; i++) begin
            idx_dist   = TAG_W'(i) - head_ptr[TAG_W-1:0];
            younger[i] = ({1'b0, idx_dist} > {1'b0, br_dist}) && ({1'b0, idx_dist} < occ);
        end
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order completion, in-order commit,
// single-cycle flush of everything younger than a mispredicted branch.
module rob_param
    import rob_param_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  op_t              alloc_op,
    input  logic [4:0]       alloc_rd,
    input  logic [4:0]       alloc_st_src,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [DEPTH-1:0] set_valid,
    input  logic             br_update,
    input  logic [TAG_W-1:0] br_tag,
    input  logic             br_mispredict,
    input  logic             data_mem_resp,
    output logic             data_read,
    output logic             data_write,
    output logic             regfile_load,
    output logic             ld_commit_sel,
    output logic [4:0]       rd_commit,
    output logic [4:0]       st_src_commit,
    output logic [TAG_W-1:0] head_tag,
    output logic [DEPTH-1:0] entry_valid,
    output logic [DEPTH-1:0] entry_alloc,
    output logic [TAG_W:0]   count,
    output logic             rob_full,
    output logic             rob_empty,
    output logic             flush,
    output logic             ld_pc
);

    op_t              op_q  [DEPTH];
    op_t              op_d  [DEPTH];
    logic [4:0]       rd_q  [DEPTH];
    logic [4:0]       rd_d  [DEPTH];
    logic [4:0]       src_q [DEPTH];
    logic [4:0]       src_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [TAG_W:0]   head_q, head_d;
    logic [TAG_W:0]   tail_q, tail_d;

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             head_ready;
    logic             retire;
    logic             do_alloc;
    logic             mispredict;
    logic [DEPTH-1:0] flush_mask;
    logic [TAG_W-1:0] br_dist;

    rob_param_age_mask #(
        .DEPTH (DEPTH)
    ) u_age_mask (
        .head_ptr (head_q),
        .tail_ptr (tail_q),
        .br_tag   (br_tag),
        .younger  (flush_mask),
        .br_dist  (br_dist)
    );

    assign head_idx    = head_q[TAG_W-1:0];
    assign tail_idx    = tail_q[TAG_W-1:0];
    assign head_tag    = head_idx;
    assign alloc_tag   = tail_idx;
    assign count       = tail_q - head_q;
    assign rob_empty   = (head_q == tail_q);
    assign rob_full    = (head_q[TAG_W] != tail_q[TAG_W]) && (head_idx == tail_idx);
    assign entry_valid = valid_q;
    assign entry_alloc = alloc_q;

    assign mispredict  = br_update & br_mispredict & alloc_q[br_tag];
    assign flush       = mispredict;
    assign ld_pc       = mispredict;
    assign alloc_ready = ~rob_full & ~(br_update & br_mispredict);
    assign do_alloc    = alloc_valid & alloc_ready;

    assign rd_commit     = rd_q[head_idx];
    assign st_src_commit = src_q[head_idx];
    assign head_ready    = alloc_q[head_idx] & valid_q[head_idx];

    always_comb begin
        data_read     = 1'b0;
        data_write    = 1'b0;
        regfile_load  = 1'b0;
        ld_commit_sel = 1'b0;
        retire        = 1'b0;
        if (head_ready) begin
            case (op_q[head_idx])
                OpLd: begin
                    data_read     = ~data_mem_resp;
                    regfile_load  = data_mem_resp;
                    ld_commit_sel = data_mem_resp;
                    retire        = data_mem_resp;
                end
                OpSt: begin
                    data_write = ~data_mem_resp;
                    retire     = data_mem_resp;
                end
                OpBr:    retire = 1'b1;
                default: begin
                    regfile_load = 1'b1;
                    retire       = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        op_d    = op_q;
        rd_d    = rd_q;
        src_d   = src_q;
        valid_d = valid_q | (set_valid & alloc_q & ~(mispredict ? flush_mask : '0));
        alloc_d = alloc_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (retire) begin
            valid_d[head_idx] = 1'b0;
            alloc_d[head_idx] = 1'b0;
            head_d            = head_q + 1'b1;
        end

        // Alloc is never granted in a mispredict cycle, so the two tail updates are exclusive.
        if (mispredict) begin
            valid_d = valid_d & ~flush_mask;
            alloc_d = alloc_d & ~flush_mask;
            tail_d  = head_q + (TAG_W+1)'(br_dist) + (TAG_W+1)'(1);
        end else if (do_alloc) begin
            op_d[tail_idx]    = alloc_op;
            rd_d[tail_idx]    = alloc_rd;
            src_d[tail_idx]   = alloc_st_src;
            valid_d[tail_idx] = 1'b0;
            alloc_d[tail_idx] = 1'b1;
            tail_d            = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= OpAlu;
                rd_q[i]  <= '0;
                src_q[i] <= '0;
            end
            valid_q <= '0;
            alloc_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            op_q    <= op_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            alloc_q <= alloc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param at DEPTH=8 with hand-computed expectations.
module tb_rob_param;
    import rob_param_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid;
    op_t        alloc_op;
    logic [4:0] alloc_rd;
    logic [4:0] alloc_st_src;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic [7:0] set_valid;
    logic       br_update;
    logic [2:0] br_tag;
    logic       br_mispredict;
    logic       data_mem_resp;
    logic       data_read;
    logic       data_write;
    logic       regfile_load;
    logic       ld_commit_sel;
    logic [4:0] rd_commit;
    logic [4:0] st_src_commit;
    logic [2:0] head_tag;
    logic [7:0] entry_valid;
    logic [7:0] entry_alloc;
    logic [3:0] count;
    logic       rob_full;
    logic       rob_empty;
    logic       flush;
    logic       ld_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rob_param #(.DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_op      (alloc_op),
        .alloc_rd      (alloc_rd),
        .alloc_st_src  (alloc_st_src),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .set_valid     (set_valid),
        .br_update     (br_update),
        .br_tag        (br_tag),
        .br_mispredict (br_mispredict),
        .data_mem_resp (data_mem_resp),
        .data_read     (data_read),
        .data_write    (data_write),
        .regfile_load  (regfile_load),
        .ld_commit_sel (ld_commit_sel),
        .rd_commit     (rd_commit),
        .st_src_commit (st_src_commit),
        .head_tag      (head_tag),
        .entry_valid   (entry_valid),
        .entry_alloc   (entry_alloc),
        .count         (count),
        .rob_full      (rob_full),
        .rob_empty     (rob_empty),
        .flush         (flush),
        .ld_pc         (ld_pc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_one(input op_t op, input logic [4:0] rd, input logic [4:0] src);
        alloc_valid = 1'b1; alloc_op = op; alloc_rd = rd; alloc_st_src = src;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; alloc_valid = 1'b0; alloc_op = OpAlu; alloc_rd = '0; alloc_st_src = '0;
        set_valid = '0; br_update = 1'b0; br_tag = '0; br_mispredict = 1'b0;
        data_mem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_vec++; if (rob_empty !== 1'b1) begin $display("FAIL reset_empty got %b want 1", rob_empty); n_err++; end
        n_vec++; if (alloc_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", alloc_ready); n_err++; end
        n_vec++; if (count !== 4'd0) begin $display("FAIL reset_count got %0d want 0", count); n_err++; end
        n_vec++; if ({regfile_load, data_read, data_write, flush, ld_pc, rob_full} !== 6'b0)
            begin $display("FAIL reset_outs got %b want 000000",
                {regfile_load, data_read, data_write, flush, ld_pc, rob_full}); n_err++; end
        n_vec++; if ({entry_alloc, entry_valid} !== 16'h0) begin $display("FAIL reset_entries got %h want 0000", {entry_alloc, entry_valid}); n_err++; end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_op = OpAlu; alloc_rd = 5'(i + 1);
            #1;
            n_vec++; if (alloc_tag !== 3'(i)) begin $display("FAIL fill_tag%0d got %0d want %0d", i, alloc_tag, i); n_err++; end
            tick();
        end
        #1;
        n_vec++; if (rob_full !== 1'b1) begin $display("FAIL fill_full got %b want 1", rob_full); n_err++; end
        n_vec++; if (alloc_ready !== 1'b0) begin $display("FAIL fill_ready got %b want 0", alloc_ready); n_err++; end
        tick();
        alloc_valid = 1'b0;
        #1;
        n_vec++; if (count !== 4'd8) begin $display("FAIL fill_count got %0d want 8", count); n_err++; end
        n_vec++; if (entry_alloc !== 8'hff) begin $display("FAIL fill_alloc got %h want ff", entry_alloc); n_err++; end
        n_vec++; if (regfile_load !== 1'b0) begin $display("FAIL fill_no_commit got %b want 0", regfile_load); n_err++; end
    endtask

    task automatic test_ooo_commit;
        set_valid = 8'h08; tick();
        set_valid = 8'h02; tick();
        set_valid = 8'h01; tick();
        set_valid = 8'h00;
        #1;
        n_vec++; if ({regfile_load, ld_commit_sel, rd_commit} !== {2'b10, 5'd1})
            begin $display("FAIL ooo_c0 got %b/%b/%0d want 1/0/1", regfile_load, ld_commit_sel, rd_commit); n_err++; end
        tick();
        n_vec++; if ({regfile_load, rd_commit, head_tag} !== {1'b1, 5'd2, 3'd1})
            begin $display("FAIL ooo_c1 got %b/%0d/%0d want 1/2/1", regfile_load, rd_commit, head_tag); n_err++; end
        tick();
        set_valid = 8'h04;
        #1;
        n_vec++; if (regfile_load !== 1'b0) begin $display("FAIL ooo_stall got %b want 0", regfile_load); n_err++; end
        tick();
        set_valid = 8'h00;
        n_vec++; if ({regfile_load, rd_commit} !== {1'b1, 5'd3})
            begin $display("FAIL ooo_c2 got %b/%0d want 1/3", regfile_load, rd_commit); n_err++; end
        tick();
        n_vec++; if ({regfile_load, rd_commit} !== {1'b1, 5'd4})
            begin $display("FAIL ooo_c3 got %b/%0d want 1/4", regfile_load, rd_commit); n_err++; end
        tick();
        n_vec++; if ({regfile_load, count} !== {1'b0, 4'd4})
            begin $display("FAIL ooo_after got %b/%0d want 0/4", regfile_load, count); n_err++; end
        set_valid = 8'hf0; tick();
        set_valid = 8'h00;
        for (int k = 4; k < 8; k++) begin
            #1;
            n_vec++; if ({regfile_load, rd_commit} !== {1'b1, 5'(k + 1)})
                begin $display("FAIL drain%0d got %b/%0d want 1/%0d", k, regfile_load, rd_commit, k + 1); n_err++; end
            tick();
        end
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd0})
            begin $display("FAIL drain_empty got %b/%0d want 1/0", rob_empty, head_tag); n_err++; end
    endtask

    task automatic test_load;
        data_mem_resp = 1'b1;
        #1;
        n_vec++; if ({regfile_load, count} !== {1'b0, 4'd0})
            begin $display("FAIL resp_idle got %b/%0d want 0/0", regfile_load, count); n_err++; end
        tick();
        data_mem_resp = 1'b0;
        alloc_one(OpLd, 5'd9, 5'd0);
        n_vec++; if (data_read !== 1'b0) begin $display("FAIL ld_not_ready got %b want 0", data_read); n_err++; end
        set_valid = 8'h01; tick();
        set_valid = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if ({data_read, regfile_load} !== 2'b10)
                begin $display("FAIL ld_wait%0d got %b want 10", c, {data_read, regfile_load}); n_err++; end
            tick();
        end
        data_mem_resp = 1'b1;
        #1;
        n_vec++; if ({data_read, regfile_load, ld_commit_sel, rd_commit} !== {3'b011, 5'd9})
            begin $display("FAIL ld_resp got %b/%0d want 011/9", {data_read, regfile_load, ld_commit_sel}, rd_commit); n_err++; end
        tick();
        data_mem_resp = 1'b0;
        #1;
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd1})
            begin $display("FAIL ld_retired got %b/%0d want 1/1", rob_empty, head_tag); n_err++; end
    endtask

    task automatic test_mispredict_wrap;
        for (int i = 0; i < 5; i++) alloc_one(OpAlu, 5'd20, 5'd0);
        set_valid = 8'h3e; tick();
        set_valid = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd6})
            begin $display("FAIL wrap_head got %b/%0d want 1/6", rob_empty, head_tag); n_err++; end
        alloc_one(OpAlu, 5'd16, 5'd0);
        alloc_one(OpBr,  5'd0,  5'd0);
        alloc_one(OpAlu, 5'd17, 5'd0);
        alloc_one(OpAlu, 5'd18, 5'd0);
        n_vec++; if ({alloc_tag, count} !== {3'd2, 4'd4})
            begin $display("FAIL wrap_tail got %0d/%0d want 2/4", alloc_tag, count); n_err++; end
        br_update = 1'b1; br_tag = 3'd7; br_mispredict = 1'b1;
        #1;
        n_vec++; if ({flush, ld_pc, alloc_ready} !== 3'b110)
            begin $display("FAIL mp_pulse got %b want 110", {flush, ld_pc, alloc_ready}); n_err++; end
        tick();
        br_update = 1'b0; br_mispredict = 1'b0;
        #1;
        n_vec++; if ({count, alloc_tag, flush} !== {4'd2, 3'd0, 1'b0})
            begin $display("FAIL mp_after got %0d/%0d/%b want 2/0/0", count, alloc_tag, flush); n_err++; end
        n_vec++; if (entry_alloc !== 8'hc0) begin $display("FAIL mp_alloc got %h want c0", entry_alloc); n_err++; end
        set_valid = 8'hc0; tick();
        set_valid = 8'h00;
        n_vec++; if ({regfile_load, head_tag, rd_commit} !== {1'b1, 3'd6, 5'd16})
            begin $display("FAIL mp_c6 got %b/%0d/%0d want 1/6/16", regfile_load, head_tag, rd_commit); n_err++; end
        tick();
        n_vec++; if ({regfile_load, data_read, data_write, head_tag} !== {3'b000, 3'd7})
            begin $display("FAIL mp_br got %b/%0d want 000/7", {regfile_load, data_read, data_write}, head_tag); n_err++; end
        tick();
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd0})
            begin $display("FAIL mp_drained got %b/%0d want 1/0", rob_empty, head_tag); n_err++; end
    endtask

    task automatic test_mispredict_conflict;
        alloc_one(OpBr,  5'd0, 5'd0);
        alloc_one(OpAlu, 5'd5, 5'd0);
        alloc_one(OpAlu, 5'd6, 5'd0);
        br_update = 1'b1; br_tag = 3'd0; br_mispredict = 1'b1;
        alloc_valid = 1'b1; alloc_op = OpAlu; set_valid = 8'h06;
        #1;
        n_vec++; if ({flush, alloc_ready} !== 2'b10)
            begin $display("FAIL cf_pulse got %b want 10", {flush, alloc_ready}); n_err++; end
        tick();
        alloc_valid = 1'b0; set_valid = 8'h00; br_mispredict = 1'b0;
        #1;
        n_vec++; if ({entry_alloc, entry_valid} !== 16'h0100)
            begin $display("FAIL cf_entries got %h want 0100", {entry_alloc, entry_valid}); n_err++; end
        n_vec++; if ({count, alloc_tag} !== {4'd1, 3'd1})
            begin $display("FAIL cf_count got %0d/%0d want 1/1", count, alloc_tag); n_err++; end
        n_vec++; if (flush !== 1'b0) begin $display("FAIL br_correct got %b want 0", flush); n_err++; end
        tick();
        br_tag = 3'd5; br_mispredict = 1'b1;
        #1;
        n_vec++; if (flush !== 1'b0) begin $display("FAIL br_unalloc got %b want 0", flush); n_err++; end
        tick();
        br_update = 1'b0; br_mispredict = 1'b0;
        #1;
        n_vec++; if ({count, entry_alloc} !== {4'd1, 8'h01})
            begin $display("FAIL br_nochange got %0d/%h want 1/01", count, entry_alloc); n_err++; end
        set_valid = 8'h01; tick();
        set_valid = 8'h00;
        tick();
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd1})
            begin $display("FAIL cf_drained got %b/%0d want 1/1", rob_empty, head_tag); n_err++; end
    endtask

    task automatic test_store;
        alloc_one(OpSt, 5'd3, 5'd12);
        set_valid = 8'h02; tick();
        set_valid = 8'h00;
        n_vec++; if ({data_write, regfile_load, st_src_commit} !== {2'b10, 5'd12})
            begin $display("FAIL st_wait got %b/%0d want 10/12", {data_write, regfile_load}, st_src_commit); n_err++; end
        tick();
        data_mem_resp = 1'b1;
        #1;
        n_vec++; if ({data_write, regfile_load} !== 2'b00)
            begin $display("FAIL st_resp got %b want 00", {data_write, regfile_load}); n_err++; end
        tick();
        data_mem_resp = 1'b0;
        n_vec++; if ({rob_empty, head_tag} !== {1'b1, 3'd2})
            begin $display("FAIL st_retired got %b/%0d want 1/2", rob_empty, head_tag); n_err++; end
    endtask

    task automatic test_reset_mid_store;
        alloc_one(OpSt, 5'd0, 5'd7);
        set_valid = 8'h04; tick();
        set_valid = 8'h00;
        rst = 1'b1;
        #1;
        n_vec++; if (data_write !== 1'b1) begin $display("FAIL rst_pre got %b want 1", data_write); n_err++; end
        tick();
        rst = 1'b0;
        #1;
        n_vec++; if ({data_write, rob_empty, count, head_tag, entry_alloc} !== {2'b01, 4'd0, 3'd0, 8'h00})
            begin $display("FAIL rst_mid got %b/%b/%0d/%0d/%h want 0/1/0/0/00",
                data_write, rob_empty, count, head_tag, entry_alloc); n_err++; end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_ooo_commit();
        test_load();
        test_mispredict_wrap();
        test_mispredict_conflict();
        test_store();
        test_reset_mid_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
